// File: rtl/taxi_trip_ctrl.sv
// taxi_trip_ctrl: trip sequencing for the taxi fare meter (vacant/hired/waiting/settle).
// Define TAXI_TRIP_LOG_EN to implement the trip_count/revenue log; otherwise both read 0.
module taxi_trip_ctrl #(
    parameter int IDLE_SEC = 3,
    parameter int FARE_W   = 14,
    parameter int LOG_W    = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_btn,
    input  logic              end_btn,
    input  logic              wheel_pulse,
    input  logic              sec_tick,
    input  logic [FARE_W-1:0] fare_in,
    input  logic              pay_ack,
    output logic              meter_clear,
    output logic              meter_dist_pulse,
    output logic              meter_wait_tick,
    output logic              meter_stop,
    output logic [FARE_W-1:0] fare_hold,
    output logic              fare_valid,
    output logic [1:0]        state,
    output logic [15:0]       trip_count,
    output logic [LOG_W-1:0]  revenue
);
    localparam logic [1:0] VACANT  = 2'd0;
    localparam logic [1:0] HIRED   = 2'd1;
    localparam logic [1:0] WAITING = 2'd2;
    localparam logic [1:0] SETTLE  = 2'd3;
    localparam logic [3:0] IDLE_MAX = 4'(IDLE_SEC);

    logic [1:0] state_nxt;
    logic [3:0] idle_cnt;
    logic       idle_hit;

    // this tick completes the idle interval, so WAITING starts next cycle
    assign idle_hit = sec_tick && !wheel_pulse && (idle_cnt + 4'd1 >= IDLE_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= VACANT;
            idle_cnt         <= '0;
            meter_dist_pulse <= 1'b0;
            meter_wait_tick  <= 1'b0;
            fare_hold        <= '0;
        end else begin
            state            <= state_nxt;
            meter_dist_pulse <= wheel_pulse && (state == HIRED || (state == WAITING && !end_btn));
            meter_wait_tick  <= sec_tick && state == WAITING;
            if (state != SETTLE && state_nxt == SETTLE)
                fare_hold <= fare_in;
            if ((state != HIRED && state_nxt == HIRED) || (state == HIRED && wheel_pulse))
                idle_cnt <= '0;
            else if (state == HIRED && sec_tick && idle_cnt < IDLE_MAX)
                idle_cnt <= idle_cnt + 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            VACANT:  state_nxt = start_btn ? HIRED : VACANT;
            HIRED:   state_nxt = end_btn ? SETTLE : idle_hit ? WAITING : HIRED;
            WAITING: state_nxt = end_btn ? SETTLE : wheel_pulse ? HIRED : WAITING;
            default: state_nxt = pay_ack ? VACANT : SETTLE;
        endcase
    end

    always_comb begin
        meter_clear = state == VACANT;
        meter_stop  = state == WAITING;
        fare_valid  = state == SETTLE;
    end

`ifdef TAXI_TRIP_LOG_EN
    logic [LOG_W:0] rev_sum;

    assign rev_sum = {1'b0, revenue} + (LOG_W+1)'(fare_hold);

    always_ff @(posedge clk) begin
        if (reset) begin
            trip_count <= '0;
            revenue    <= '0;
        end else if (state == SETTLE && pay_ack) begin
            trip_count <= trip_count + 16'd1;
            revenue    <= rev_sum[LOG_W] ? '1 : rev_sum[LOG_W-1:0];
        end
    end
`else
    assign trip_count = '0;
    assign revenue    = '0;
`endif
endmodule

// File: tb/tb_taxi_trip_ctrl.sv
// tb_taxi_trip_ctrl: directed checks of taxi_trip_ctrl, with or without TAXI_TRIP_LOG_EN.
module tb_taxi_trip_ctrl;
`ifdef TAXI_TRIP_LOG_EN
    localparam bit LOG = 1'b1;
`else
    localparam bit LOG = 1'b0;
`endif
    logic        clk = 0, reset = 1, start_btn = 0, end_btn = 0, wheel_pulse = 0, sec_tick = 0, pay_ack = 0;
    logic [13:0] fare_in = 0;
    logic        meter_clear, meter_dist_pulse, meter_wait_tick, meter_stop, fare_valid;
    logic [13:0] fare_hold;
    logic [1:0]  state;
    logic [15:0] trip_count;
    logic [23:0] revenue;
    int          vectors = 0, miscompares = 0;
    longint      rev_m = 0;
    int          trips_m = 0;

    taxi_trip_ctrl dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .end_btn(end_btn),
        .wheel_pulse(wheel_pulse), .sec_tick(sec_tick), .fare_in(fare_in), .pay_ack(pay_ack),
        .meter_clear(meter_clear), .meter_dist_pulse(meter_dist_pulse),
        .meter_wait_tick(meter_wait_tick), .meter_stop(meter_stop), .fare_hold(fare_hold),
        .fare_valid(fare_valid), .state(state), .trip_count(trip_count), .revenue(revenue)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        start_btn = 0; end_btn = 0; wheel_pulse = 0; sec_tick = 0; pay_ack = 0;
    endtask

    task automatic paid(input logic [13:0] f);
        rev_m   = rev_m + f;
        if (rev_m > 64'd16777215) rev_m = 16777215;
        trips_m = trips_m + 1;
    endtask

    task automatic trip(input logic [13:0] f);
        start_btn = 1; cyc(); clr();
        end_btn = 1; fare_in = f; cyc(); clr();
        pay_ack = 1; cyc(); clr();
        paid(f);
    endtask

    initial begin
        cyc(); cyc();
        reset = 0;
        chk("rst_state", state, 0);
        chk("rst_clear", meter_clear, 1);
        chk("rst_dist", meter_dist_pulse, 0);
        chk("rst_wait", meter_wait_tick, 0);
        chk("rst_stop", meter_stop, 0);
        chk("rst_hold", fare_hold, 0);
        chk("rst_valid", fare_valid, 0);
        chk("rst_trips", trip_count, 0);
        chk("rst_rev", revenue, 0);

        start_btn = 1; cyc(); clr();
        chk("hired_state", state, 1);
        chk("hired_clear", meter_clear, 0);
        for (int i = 0; i < 5; i++) begin
            wheel_pulse = 1; cyc(); clr();
            chk("dist_on", meter_dist_pulse, 1);
            cyc();
            chk("dist_off", meter_dist_pulse, 0);
        end

        for (int i = 0; i < 3; i++) begin
            chk("pre_idle_state", state, 1);
            sec_tick = 1; cyc(); clr();
        end
        chk("wait_state", state, 2);
        chk("wait_stop", meter_stop, 1);
        for (int i = 0; i < 4; i++) begin
            sec_tick = 1; cyc(); clr();
            chk("wtick_on", meter_wait_tick, 1);
            cyc();
            chk("wtick_off", meter_wait_tick, 0);
        end
        wheel_pulse = 1; cyc(); clr();
        chk("resume_state", state, 1);
        chk("resume_dist", meter_dist_pulse, 1);
        chk("resume_stop", meter_stop, 0);

        start_btn = 1; cyc(); clr();
        chk("start_ignored", state, 1);
        for (int i = 0; i < 3; i++) begin
            sec_tick = 1; cyc(); clr();
        end
        chk("wait_again", state, 2);
        end_btn = 1; wheel_pulse = 1; fare_in = 122; cyc(); clr();
        chk("end_prio_state", state, 3);
        chk("end_prio_dist", meter_dist_pulse, 0);
        chk("settle_hold", fare_hold, 122);
        chk("settle_valid", fare_valid, 1);
        chk("settle_stop", meter_stop, 0);
        fare_in = 5; start_btn = 1; sec_tick = 1; cyc(); clr();
        chk("settle_stay", state, 3);
        chk("settle_hold_stable", fare_hold, 122);
        chk("settle_no_wtick", meter_wait_tick, 0);
        pay_ack = 1; cyc(); clr();
        paid(122);
        chk("paid_valid", fare_valid, 0);
        chk("paid_state", state, 0);
        chk("paid_trips", trip_count, LOG ? 1 : 0);
        chk("paid_rev", revenue, LOG ? 122 : 0);

        end_btn = 1; pay_ack = 1; cyc(); clr();
        chk("vacant_ignore", state, 0);
        chk("vacant_clear", meter_clear, 1);

        start_btn = 1; cyc(); clr();
        sec_tick = 1; cyc(); clr();
        sec_tick = 1; cyc(); clr();
        sec_tick = 1; end_btn = 1; fare_in = 10; cyc(); clr();
        chk("end_over_idle", state, 3);
        chk("end_over_idle_hold", fare_hold, 10);
        pay_ack = 1; cyc(); clr();
        paid(10);
        chk("trip2_rev", revenue, LOG ? 32'(rev_m) : 0);

        for (int i = 0; i < 1024; i++) trip(14'h3fff);
        chk("near_sat_rev", revenue, LOG ? 32'(rev_m) : 0);
        chk("near_sat_trips", trip_count, LOG ? 32'(trips_m) : 0);
        trip(14'h3fff);
        chk("sat_rev", revenue, LOG ? 32'd16777215 : 0);
        chk("sat_trips", trip_count, LOG ? 32'(trips_m) : 0);

        start_btn = 1; cyc(); clr();
        end_btn = 1; fare_in = 77; cyc(); clr();
        chk("abort_pre_state", state, 3);
        reset = 1; cyc(); reset = 0;
        chk("abort_state", state, 0);
        chk("abort_valid", fare_valid, 0);
        chk("abort_hold", fare_hold, 0);
        chk("abort_trips", trip_count, LOG ? 32'(trips_m) : 0);
        chk("abort_rev", revenue, LOG ? 32'(rev_m) : 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/taxi_trip_ctrl.md
# taxi_trip_ctrl

Trip-sequencing controller for the taxi fare meter datapath. It turns driver buttons, wheel pulses and a 1 Hz tick into the meter's clear, distance-pulse and wait-tick controls. It automatically switches between running and waiting billing. At trip end it freezes the meter's fare and holds it for the payment terminal through a valid/ack handshake.

## Interface
- IDLE_SEC, 3: whole seconds with no wheel pulse before HIRED switches to WAITING (1..15)
- FARE_W, 14: fare width, matches the meter's money output
- LOG_W, 24: width of the revenue accumulator
- clk  in  1  system clock; all inputs are single-cycle strobes synchronous to clk
- reset  in  1  reset, synchronous, active-high
- start_btn  in  1  driver accepts a passenger
- end_btn  in  1  driver ends the trip
- wheel_pulse  in  1  one strobe per 10 m travelled
- sec_tick  in  1  one strobe per second
- fare_in  in  FARE_W  live fare from the meter datapath
- pay_ack  in  1  payment terminal has consumed fare_hold
- meter_clear  out  1  clears meter distance/wait/fare counters
- meter_dist_pulse  out  1  forwarded wheel pulse (meter distance clock enable)
- meter_wait_tick  out  1  forwarded sec_tick while waiting
- meter_stop  out  1  high in WAITING (meter stop input)
- fare_hold  out  FARE_W  frozen trip fare
- fare_valid  out  1  fare_hold is valid and awaiting pay_ack
- state  out  2  0 VACANT, 1 HIRED, 2 WAITING, 3 SETTLE
- trip_count  out  16  completed paid trips
- revenue  out  LOG_W  sum of paid fares

## Operation
- VACANT: meter_clear=1. start_btn -> HIRED. end_btn and pay_ack are ignored.
- HIRED:
  - Each wheel_pulse is forwarded to meter_dist_pulse and clears idle_cnt.
  - Each sec_tick without a same-cycle wheel_pulse increments idle_cnt.
  - When idle_cnt reaches IDLE_SEC -> WAITING.
  - end_btn -> SETTLE. It takes priority over the idle transition in the same cycle.
- WAITING:
  - meter_stop=1; each sec_tick is forwarded to meter_wait_tick.
  - wheel_pulse -> HIRED. That pulse is also forwarded as distance, and idle_cnt is cleared.
  - end_btn -> SETTLE. It takes priority over wheel_pulse.
- SETTLE:
  - On the entering transition, fare_hold <= fare_in as sampled in that cycle.
  - fare_valid=1 until pay_ack. No forwarding; meter_stop=0; start_btn is ignored.
  - pay_ack -> VACANT and fare_valid drops.
- start_btn while HIRED or WAITING is ignored.
- idle_cnt is 4 bits and saturates at IDLE_SEC. It is cleared on every entry to HIRED.
- Arithmetic rules:
  - revenue adds a zero-extended fare_hold and saturates at all-ones.
  - trip_count wraps modulo 2^16.

## Timing
- All outputs are registered.
- meter_dist_pulse and meter_wait_tick appear 1 cycle after the qualifying input strobe and are 1 cycle wide.
- State changes take effect the cycle after the triggering strobe. Decoded outputs (meter_clear, meter_stop, fare_valid) follow the new state in that same cycle.
- fare_hold is stable from the cycle fare_valid rises until the next SETTLE entry.
- pay_ack with fare_valid high: fare_valid is low in the next cycle. trip_count and revenue update in that same cycle.
- Reset mid-trip aborts the trip with no logging.
- Reset values:
  - state=VACANT, meter_clear=1.
  - meter_dist_pulse=0, meter_wait_tick=0, meter_stop=0.
  - fare_hold=0, fare_valid=0, idle_cnt=0.
  - trip_count=0, revenue=0.

## Configuration
- TAXI_TRIP_LOG_EN defined: trip_count and revenue are implemented as described.
- TAXI_TRIP_LOG_EN undefined: trip_count and revenue are tied to 0, and no accumulator logic is synthesized.
- All other behaviour is identical with or without the macro.

## Test plan
- Reset, then start_btn: state 0->1, meter_clear 1->0 the next cycle; 5 wheel_pulses give 5 meter_dist_pulses, each 1 cycle late.
- HIRED, 3 sec_ticks with no wheel_pulse (IDLE_SEC=3): state=2 and meter_stop=1. The next 4 sec_ticks give 4 meter_wait_ticks. One wheel_pulse returns state to 1 and produces 1 meter_dist_pulse.
- WAITING, end_btn and wheel_pulse in the same cycle: state=3 and no meter_dist_pulse.
- fare_in=122 at end_btn: fare_hold=122 and fare_valid=1. pay_ack gives fare_valid=0, state=0, trip_count=1, revenue=122 (with the macro); trip_count and revenue stay 0 without the macro.
- revenue preset near 2^24-1 via repeated trips: an overflowing fare leaves revenue=16777215.
- Reset asserted in SETTLE before pay_ack: state=0, fare_valid=0, and trip_count unchanged.
